// File: rtl/perf_pkg.sv
// perf_pkg: shared types and defaults for the performance-counter bank.
//   perf_cfg_t  - per-counter configuration {en, evt_sel}
//   DEF_*       - default parameter values for perf_counter_bank
//   perf_evt_e  - event-vector bit positions used by the core
package perf_pkg;

  localparam int DEF_NUM_CNT  = 8;
  localparam int DEF_NUM_EVT  = 8;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_SATURATE = 0;
  localparam int DEF_BASE_IDX = 0;
  localparam int DEF_STAT_IDX = 31;

  // evt_sel is always carried at the full 5-bit range so one slice type
  // serves every NUM_EVT; the top zero-extends the configured selection.
  typedef struct packed {
    logic       en;
    logic [4:0] evt_sel;
  } perf_cfg_t;

  typedef enum logic [4:0] {
    EVT_L1I_HIT = 5'd0,
    EVT_L1I_ACC = 5'd1,
    EVT_L1D_HIT = 5'd2,
    EVT_L1D_ACC = 5'd3,
    EVT_L2_HIT  = 5'd4,
    EVT_L2_ACC  = 5'd5,
    EVT_BR      = 5'd6,
    EVT_BR_MISS = 5'd7,
    EVT_STALL   = 5'd8
  } perf_evt_e;

endpackage

// File: rtl/perf_cnt_slice.sv
// perf_cnt_slice: one performance counter.
// Owns the event-select mux, increment with wrap/saturate, sticky overflow,
// its configuration register and, when PERF_SNAPSHOT_EN is defined, a
// shadow copy of count and overflow.
// Ports:
//   clk, reset     clock, async active-high reset
//   evt            event strobes, zero-padded to 32 bits
//   cfg_hit        configuration write addressed to this counter
//   cfg_in         configuration to load on cfg_hit
//   clr            synchronous clear of count, overflow and shadow
//   freeze         hold the count
//   snap           copy live state into the shadow (snapshot builds)
//   rd_count       value presented to reads (live or shadow)
//   rd_ovf         overflow bit presented to reads (live or shadow)
module perf_cnt_slice
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = DEF_SATURATE,
  parameter int RST_SEL  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      evt,
  input  logic             cfg_hit,
  input  perf_cfg_t        cfg_in,
  input  logic             clr,
  input  logic             freeze,
  input  logic             snap,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_ovf
);

  perf_cfg_t        cfg;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             inc;

  assign inc = cfg.en && evt[cfg.evt_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
      cfg   <= '{en: 1'b1, evt_sel: 5'(RST_SEL)};
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (cfg_hit) begin
      cfg   <= cfg_in;
      count <= '0;
      ovf   <= 1'b0;
    end else if (!freeze && inc) begin
      if (&count) begin
        ovf <= 1'b1;
        // saturating builds simply hold all-ones
        if (SATURATE == 0) count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow;
  logic             shadow_ovf;

  // Captures the pre-edge count, so a coincident increment is not included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      shadow_ovf <= 1'b0;
    end else if (clr) begin
      shadow     <= '0;
      shadow_ovf <= 1'b0;
    end else if (snap) begin
      shadow     <= count;
      shadow_ovf <= ovf;
    end
  end

  assign rd_count = shadow;
  assign rd_ovf   = shadow_ovf;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign rd_count    = count;
  assign rd_ovf      = ovf;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: parametrised bank of event counters with a
// combinational read port indexed by a 5-bit register number.
// Optional feature macro: PERF_SNAPSHOT_EN (shadow registers + snap).
// Ports:
//   clk          sole clock
//   reset        async active-high reset
//   evt_vec      per-cycle event strobes
//   cfg_we       write configuration of counter cfg_idx
//   cfg_idx      counter being configured (out-of-range ignored)
//   cfg_evt_sel  event index to count
//   cfg_en       counter enable
//   clr          clear counts, shadows and overflow bits
//   freeze       hold all counts
//   snap         capture snapshot (snapshot builds only)
//   read_src     read index
//   read_data    counter value / overflow status / 0
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT  = DEF_NUM_CNT,
  parameter int NUM_EVT  = DEF_NUM_EVT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = DEF_SATURATE,
  parameter int BASE_IDX = DEF_BASE_IDX,
  parameter int STAT_IDX = DEF_STAT_IDX,
  localparam int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt_vec,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [SEL_W-1:0]   cfg_evt_sel,
  input  logic               cfg_en,
  input  logic               clr,
  input  logic               freeze,
  input  logic               snap,
  input  logic [4:0]         read_src,
  output logic [31:0]        read_data
);

  logic [31:0]      evt_pad;
  perf_cfg_t        cfg_in;
  logic [CNT_W-1:0] cnt_rd [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_rd;

  // Padding lets an out-of-range selection read a constant 0 strobe.
  assign evt_pad = 32'(evt_vec);
  assign cfg_in  = '{en: cfg_en, evt_sel: 5'(cfg_evt_sel)};

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_cnt_slice #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE),
      .RST_SEL  (i % NUM_EVT)
    ) u_slice (
      .clk      (clk),
      .reset    (reset),
      .evt      (evt_pad),
      .cfg_hit  (cfg_we && (32'(cfg_idx) == i)),
      .cfg_in   (cfg_in),
      .clr      (clr),
      .freeze   (freeze),
      .snap     (snap),
      .rd_count (cnt_rd[i]),
      .rd_ovf   (ovf_rd[i])
    );
  end

  always_comb begin
    read_data = '0;
    if (read_src == 5'(STAT_IDX)) begin
      read_data = 32'(ovf_rd);
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (read_src == 5'(BASE_IDX + i)) read_data = 32'(cnt_rd[i]);
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

  localparam int ND = 3;
  localparam int NC = 8;
  localparam int W_OF  [ND] = '{32, 8, 8};
  localparam int SAT_OF[ND] = '{0, 0, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  evt_vec;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [2:0]  cfg_evt_sel;
  logic        cfg_en;
  logic        clr;
  logic        freeze;
  logic        snap;
  logic [4:0]  read_src;
  logic [31:0] rd0, rd1, rd2;

  always #5 clk = ~clk;

  perf_counter_bank #(.CNT_W(32), .SATURATE(0)) u_dut0 (
    .clk(clk), .reset(reset), .evt_vec(evt_vec), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_evt_sel(cfg_evt_sel), .cfg_en(cfg_en), .clr(clr), .freeze(freeze), .snap(snap),
    .read_src(read_src), .read_data(rd0));
  perf_counter_bank #(.CNT_W(8), .SATURATE(0)) u_dut1 (
    .clk(clk), .reset(reset), .evt_vec(evt_vec), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_evt_sel(cfg_evt_sel), .cfg_en(cfg_en), .clr(clr), .freeze(freeze), .snap(snap),
    .read_src(read_src), .read_data(rd1));
  perf_counter_bank #(.CNT_W(8), .SATURATE(1)) u_dut2 (
    .clk(clk), .reset(reset), .evt_vec(evt_vec), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_evt_sel(cfg_evt_sel), .cfg_en(cfg_en), .clr(clr), .freeze(freeze), .snap(snap),
    .read_src(read_src), .read_data(rd2));

  // reference model: plain integer counts per counter
  longint m_cnt [ND][NC];
  bit     m_ovf [ND][NC];
  longint m_sh  [ND][NC];
  bit     m_shovf[ND][NC];
  int     m_sel [NC];
  bit     m_en  [NC];

  // inputs currently applied to the DUTs (acted on at the next edge)
  logic [7:0] a_evt;
  bit a_we, a_en, a_clr, a_frz, a_snap;
  int a_idx, a_sel;

  typedef struct packed {
    logic [ND-1:0][31:0] exp;
    logic [4:0]          src;
  } sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_sel[i] = i % 8;
      m_en[i]  = 1'b1;
      for (int d = 0; d < ND; d++) begin
        m_cnt[d][i] = 0; m_ovf[d][i] = 0; m_sh[d][i] = 0; m_shovf[d][i] = 0;
      end
    end
  endfunction

  function automatic void model_edge();
    longint maxv;
    for (int d = 0; d < ND; d++) begin
      maxv = (64'd1 << W_OF[d]) - 1;
      for (int i = 0; i < NC; i++) begin
        if (a_snap && !a_clr) begin
          m_sh[d][i] = m_cnt[d][i];
          m_shovf[d][i] = m_ovf[d][i];
        end
        if (a_clr) begin
          m_cnt[d][i] = 0; m_ovf[d][i] = 0; m_sh[d][i] = 0; m_shovf[d][i] = 0;
        end else if (a_we && a_idx == i) begin
          m_cnt[d][i] = 0; m_ovf[d][i] = 0;
        end else if (!a_frz && m_en[i] && a_evt[m_sel[i]]) begin
          if (m_cnt[d][i] + 1 > maxv) begin
            m_ovf[d][i] = 1;
            m_cnt[d][i] = (SAT_OF[d] != 0) ? maxv : 0;
          end else begin
            m_cnt[d][i] = m_cnt[d][i] + 1;
          end
        end
      end
    end
    if (a_we && !a_clr) begin
      m_sel[a_idx] = a_sel;
      m_en[a_idx]  = a_en;
    end
  endfunction

  function automatic logic [31:0] exp_read(int d, int src);
    logic [31:0] v;
    v = '0;
    if (src == 31) begin
      for (int i = 0; i < NC; i++)
`ifdef PERF_SNAPSHOT_EN
        v[i] = m_shovf[d][i];
`else
        v[i] = m_ovf[d][i];
`endif
    end else if (src < NC) begin
`ifdef PERF_SNAPSHOT_EN
      v = 32'(m_sh[d][src]);
`else
      v = 32'(m_cnt[d][src]);
`endif
    end
    return v;
  endfunction

  task automatic push(int src);
    sb_t e;
    for (int d = 0; d < ND; d++) e.exp[d] = exp_read(d, src);
    e.src = 5'(src);
    sb.push_back(e);
  endtask

  task automatic apply(logic [7:0] evt, bit we, int idx, int sel, bit en,
                       bit c, bit f, bit s, int src);
    evt_vec = evt; cfg_we = we; cfg_idx = 3'(idx); cfg_evt_sel = 3'(sel);
    cfg_en = en; clr = c; freeze = f; snap = s; read_src = 5'(src);
    a_evt = evt; a_we = we; a_idx = idx; a_sel = sel; a_en = en;
    a_clr = c; a_frz = f; a_snap = s;
  endtask

  task automatic cycle(logic [7:0] evt, bit we, int idx, int sel, bit en,
                       bit c, bit f, bit s, int src);
    @(posedge clk); #1;
    model_edge();
    apply(evt, we, idx, sel, en, c, f, s, src);
    push(src);
  endtask

  task automatic ev(logic [7:0] evt, int src);
    cycle(evt, 0, 0, 0, 0, 0, 0, 0, src);
  endtask

  task automatic sweep();
    for (int r = 0; r < 32; r++) ev(8'h00, r);
  endtask

  // monitor: read_data is combinational, sampled mid-cycle
  always @(negedge clk) begin
    sb_t e;
    logic [31:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int d = 0; d < ND; d++) begin
        got = (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
        checks++;
        if (got !== e.exp[d]) begin
          errors++;
          $display("FAIL read dut%0d src=%0d got %h expected %h at %0t",
                   d, e.src, got, e.exp[d], $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    apply(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12 reset = 1'b0;

    sweep();
    repeat (10) ev(8'h01, 0);
    sweep();

    // reconfigure counter 2 after it reaches 4; coincident events dropped
    repeat (4) ev(8'h04, 2);
    cycle(8'h24, 1, 2, 5, 1, 0, 0, 0, 2);
    ev(8'h20, 2);
    ev(8'h20, 2);
    ev(8'h20, 2);
    ev(8'h00, 2);

    // wrap / saturate on counter 0
    cycle(8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (257) ev(8'h01, 31);
    ev(8'h00, 0);
    ev(8'h00, 31);
    repeat (43) ev(8'h01, 0);
    sweep();

    // clr with event, then freeze, then resume
    cycle(8'h01, 0, 0, 0, 0, 1, 0, 0, 0);
    ev(8'h00, 0);
    repeat (3) ev(8'h01, 0);
    repeat (5) cycle(8'h01, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) ev(8'h01, 0);
    ev(8'h00, 0);

    // snapshot sequence
    cycle(8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (5) ev(8'h01, 0);
    cycle(8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) ev(8'h01, 0);
    ev(8'h00, 0);
    cycle(8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    ev(8'h00, 0);
    // snap coincident with increment, and snap coincident with clr
    cycle(8'h01, 0, 0, 0, 0, 0, 0, 1, 0);
    ev(8'h00, 0);
    cycle(8'h01, 0, 0, 0, 0, 1, 0, 1, 0);
    ev(8'h00, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int pick, src;
      pick = $urandom_range(0, 9);
      src = (pick < 8) ? pick : (pick == 8) ? 31 : $urandom_range(8, 30);
      cycle(8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, src);
    end
    cycle(8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    sweep();

    // async reset between edges while counting
    repeat (5) ev(8'hFF, 0);
    @(posedge clk); #1;
    model_edge();
    apply(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    push(0);
    @(posedge clk); #1;
    reset = 1'b0;
    apply(8'h00, 0, 0, 0, 0, 0, 0, 0, 31);
    push(31);

    // default selection mapping restored
    ev(8'hFF, 0);
    ev(8'h08, 0);
    cycle(8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    sweep();

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised performance-counter bank for the pipelined RV32I core. It generalises the fixed-event counter block with a configurable number of counters, counter width and overflow mode, run-time event selection per counter, sticky overflow status, global clear/freeze and optional snapshot. Reads are combinational and indexed by a 5-bit register number, so the EXE stage can read a counter with its `rs1` field.

## Interface
- `NUM_CNT`, default 8: number of counters, 1..31.
- `NUM_EVT`, default 8: width of the event vector, 1..32.
- `CNT_W`, default 32: counter width, 8..32. Reads are zero-extended to 32 bits.
- `SATURATE`, default 0: overflow mode. 0 = wrap, 1 = saturate at all-ones.
- `BASE_IDX`, default 0: `read_src` value that maps to counter 0.
- `STAT_IDX`, default 31: `read_src` value that returns the overflow status word.
- Constraint: `BASE_IDX + NUM_CNT <= STAT_IDX`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `evt_vec`  in  NUM_EVT  per-cycle event strobes (hit, access, branch, stall, ...).
- `cfg_we`  in  1  write the configuration of one counter.
- `cfg_idx`  in  $clog2(NUM_CNT)  counter being configured.
- `cfg_evt_sel`  in  $clog2(NUM_EVT)  event index to count.
- `cfg_en`  in  1  counter enable.
- `clr`  in  1  synchronous clear of all counters, shadows and overflow bits.
- `freeze`  in  1  hold all counters.
- `snap`  in  1  capture a snapshot (snapshot builds only).
- `read_src`  in  5  read index.
- `read_data`  out  32  combinational read value.

## Operation
- Reset values:
  - Counter i: count 0, `evt_sel = i % NUM_EVT`, `en = 1`.
  - All overflow bits 0.
  - All shadow registers 0.
  - `read_data` therefore reads 0 for every index.
- Counter i increments on a rising edge when all of these hold in the preceding cycle: `en_i`, `evt_vec[evt_sel_i]`, `!freeze`, `!clr`, and no `cfg_we` to i.
- Overflow, when an increment occurs at all-ones:
  - `SATURATE=0`: the counter wraps to 0 and `ovf_i` is set.
  - `SATURATE=1`: the counter holds all-ones and `ovf_i` is set.
  - `ovf_i` is sticky until `clr`, `reset`, or `cfg_we` to i.
- `cfg_we`:
  - loads `evt_sel` and `en` into counter `cfg_idx`;
  - zeroes that counter and its `ovf` bit;
  - the new selection is first counted in the cycle after the write;
  - a `cfg_idx >= NUM_CNT` is ignored.
- Priority per counter: `reset` > `clr` > `cfg_we` > `freeze` > increment.
- `clr` zeroes counts, shadows and overflow bits. Configuration is kept.
- `freeze` holds counts only. `cfg_we`, `clr` and `snap` remain effective.
- Read map:
  - `BASE_IDX..BASE_IDX+NUM_CNT-1`: counter value, zero-extended.
  - `STAT_IDX`: `{zeros, ovf[NUM_CNT-1:0]}`.
  - Any other index: 0.

## Timing
- An event strobe in cycle k is visible on `read_data` in cycle k+1 (live reads).
- `read_data` is purely combinational from `read_src` and state, with no added latency.
- `clr` and `cfg_we` take effect at the next edge. Reads in that same cycle still return the old value.
- Asynchronous `reset` forces all state to reset values immediately, mid-count, without a clock edge.
- An event coincident with `clr`, or with `cfg_we` to the same counter, is dropped.
- Events to other counters in a `cfg_we` cycle count normally.

## Configuration
- Macro: `PERF_SNAPSHOT_EN`.
- Defined:
  - one shadow register per counter plus a shadow overflow word;
  - `snap` copies all live counts and `ovf` into the shadows at the edge;
  - all counter and status reads return shadow values;
  - `snap` coincident with an increment captures the pre-increment value;
  - `clr` in the same cycle as `snap` wins.
- Undefined:
  - no shadow registers are built and `snap` is ignored;
  - reads return live values.

## Structure
- Package `perf_pkg` holds:
  - `perf_cfg_t` struct {`en`, `evt_sel`};
  - default parameter constants;
  - the event-index enum for core events: `EVT_L1I_HIT`, `EVT_L1I_ACC`, `EVT_L1D_HIT`, `EVT_L1D_ACC`, `EVT_L2_HIT`, `EVT_L2_ACC`, `EVT_BR`, `EVT_BR_MISS`, `EVT_STALL`.
- Sub-module `perf_cnt_slice`, one instance per counter. It owns the event-select mux, increment, wrap/saturate, overflow bit, configuration register and optional shadow.
- The top level holds the generate loop and the read mux.

## Test plan
- Default parameters: reset, then hold `evt_vec=8'h01` for 10 cycles. `read_src=0` returns 10. `read_src=1..7` return 0.
- `cfg_we` with idx 2, sel 5, en 1, after counter 2 has reached 4. The counter reads 0 next cycle. Three `evt_vec[5]` pulses then give `read_src=2` → 3.
- `CNT_W=8`:
  - `SATURATE=0`: 257 events give counter 1 and `read_src=31` → `32'h1`.
  - `SATURATE=1`: 300 events give 255 and overflow bit 0 set.
- `clr` asserted together with an event: the next read is 0. With `freeze=1` for 5 eventful cycles, the count is unchanged. After release, counting resumes.
- Snapshot builds: count to 5, pulse `snap`, then 4 more events; the read is 5. A second `snap` gives 9. Without `PERF_SNAPSHOT_EN`, the same stimulus reads 9 immediately.
- Assert `reset` asynchronously mid-count, between edges. `read_data` goes to 0 before the next edge. Default `evt_sel` mapping is restored.
